// File: rtl/multiword_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multiword_add_sequencer (with helper ripple_carry_adder)
// Brief    : Wide add/subtract built from one WIDTH-bit ripple-carry adder.
//            Operands are processed one word per cycle, least significant word
//            first, with the carry registered between words.
// Revision : 1.0 - initial release
// ============================================================================

// Plain WIDTH-bit ripple-carry adder that the sequencer reuses for every word.
module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_c[WIDTH];
endmodule

module multiword_add_sequencer #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);
    localparam int W    = WIDTH * WORDS;
    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;       // already inverted for subtraction
    logic            r_carry;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;

    logic            w_accept;
    logic            w_last;
    logic [WIDTH-1:0] w_a_word;
    logic [WIDTH-1:0] w_b_word;
    logic [WIDTH-1:0] w_add_sum;
    logic            w_add_cout;
    logic            w_msb_cin;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_idx == c_LAST_IDX);
    assign w_a_word = r_a[r_idx*WIDTH +: WIDTH];
    assign w_b_word = r_b[r_idx*WIDTH +: WIDTH];

    ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // Carry into the top bit recovered from the MSB sum bit; only meaningful on the last word.
    assign w_msb_cin = w_a_word[WIDTH-1] ^ w_b_word[WIDTH-1] ^ w_add_sum[WIDTH-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and handshake outputs, decoded from the registered state only.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_ADD;
                end
            end
            S_ADD: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture and word-serial accumulation of the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                    end
                end
                S_ADD: begin
                    r_sum[r_idx*WIDTH +: WIDTH] <= w_add_sum;
                    r_carry <= w_add_cout;
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_cout <= w_add_cout;
                        r_ovf  <= w_msb_cin ^ w_add_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule

`default_nettype wire
